fact_job_scheduler: RTL and testbench
=====================================

// Module: fact_job_scheduler
// PURPOSE
//  Shares one factorial engine between NUM_REQ requesters (CPU MMIO port, GPIO port, ...).
//  Round-robin arbitration, one job in flight. Latches operand n, pulses go, waits for done,
//  returns the 32-bit result to the winning requester with a one-cycle response pulse.
//  Sits between the requesters and the factorial engine inside the factorial accelerator top.
// PARAMETERS
//  NUM_REQ      2    number of requesters (2..8)
//  TIMEOUT_CYC  255  WAIT cycles before a job is aborted with rsp_err=1 (1..65535)
// PORTS
//  clk          in   1           system clock; all logic on posedge
//  rst          in   1           synchronous, active-high reset
//  req          in   NUM_REQ     per-requester request level
//  req_n        in   4*NUM_REQ   operand n of requester i at [4i+3:4i]
//  gnt          out  NUM_REQ     one-hot owner of the current job; 0 in IDLE
//  rsp_valid    out  NUM_REQ     one-cycle response pulse to the owner
//  rsp_result   out  32          result; valid while rsp_valid != 0
//  rsp_err      out  1           job aborted (timeout or overflow); valid with rsp_valid
//  busy         out  1           state != IDLE
//  fact_go      out  1           one-cycle start pulse to engine
//  fact_n       out  4           operand to engine; stable from LAUNCH until return to IDLE
//  fact_done    in   1           engine done
//  fact_result  in   32          engine result; sampled in the cycle fact_done=1
// BEHAVIOUR
//  - Reset: state=IDLE, rr pointer=0, gnt=0, rsp_valid=0, rsp_result=0, rsp_err=0, busy=0,
//    fact_go=0, fact_n=0, timeout counter=0. Reset mid-job abandons it; no response issued.
//  - FSM: IDLE -> LAUNCH -> WAIT -> RESP -> IDLE.
//  - IDLE: if req!=0, winner = first set bit at/after pointer (wrapping); latch index and
//    req_n[winner]; gnt one-hot next cycle; -> LAUNCH. req=0 stays IDLE.
//  - LAUNCH (1 cycle): fact_go=1, fact_n=latched n, counter cleared; -> WAIT.
//    fact_done in LAUNCH is ignored (stale from previous job).
//  - WAIT: counter increments each cycle. fact_done=1 -> capture fact_result, err=0, -> RESP.
//    counter reaches TIMEOUT_CYC with no done -> result=0, err=1, -> RESP.
//    Done and timeout in the same cycle: done wins.
//  - RESP (1 cycle): rsp_valid[owner]=1, rsp_result/rsp_err driven; pointer = owner+1 mod
//    NUM_REQ; gnt cleared on exit; -> IDLE. rsp_result/rsp_err hold until next RESP.
//  - Latency: req sampled high in IDLE at edge t -> fact_go high cycle t+1 -> rsp_valid one
//    cycle after done is sampled. Min turnaround IDLE->IDLE = 4 cycles + engine time.
//  - Requester holds req and req_n stable until its rsp_valid; req still high the cycle after
//    rsp_valid counts as a new request (now lowest priority by rotation).
//  - req_n changes after latch do not affect the running job. Non-owner req ignored until IDLE.
//  - fact_go never asserted outside LAUNCH; at most one job in flight.
// CONFIGURATION
//  - FACT_OVF_CHECK_EN defined: in IDLE, latched n > 12 (32-bit overflow) skips LAUNCH/WAIT;
//    IDLE -> RESP directly, result=0, err=1, fact_go not pulsed. Pointer rotates as usual.
//  - Undefined: all n 0..15 launched; result is whatever the engine returns (truncated), err=0
//    except on timeout.
// STRUCTURE
//  - Shared header fact_pkg.vh: state encodings (S_IDLE, S_LAUNCH, S_WAIT, S_RESP, 2 bits),
//    FACT_N_W=4, FACT_RES_W=32, FACT_N_MAX=12.
//  - One sub-module: rr_arbiter (NUM_REQ param; inputs req, ptr; output one-hot grant, index).
//  - FSM, operand/result latches, timeout counter in this module.
// TESTING
//  - Single job: req=01, n=5 -> fact_go pulse 1 cycle, fact_n=5; rsp_valid=01, result=120, err=0.
//  - Contention: req=11 from IDLE after reset -> req0 served first, then req1; pointer rotates;
//    back-to-back held req=11 alternates 0,1,0,1.
//  - Timeout: TIMEOUT_CYC=8, engine never raises done -> rsp_valid after 8 WAIT cycles,
//    result=0, err=1.
//  - Stale done: fact_done=1 in LAUNCH cycle ignored; job completes only on a later done.
//  - Reset mid-WAIT: rst=1 one cycle -> gnt=0, busy=0, no rsp_valid; next req0 n=3 -> result 6.
//  - FACT_OVF_CHECK_EN: n=13 -> no fact_go, rsp_valid 1 cycle after grant, err=1; n=12 ->
//    result 479001600, err=0. Without macro, n=13 launches normally.

Source files
------------

// File: rtl/fact_job_scheduler_pkg.sv
// Shared types and widths for the factorial job scheduler: FSM state encoding,
// operand/result widths and the largest operand whose factorial fits in 32 bits.
package fact_job_scheduler_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam int FACT_N_W   = 4;
    localparam int FACT_RES_W = 32;
    localparam int FACT_N_MAX = 12;

    localparam int TIMER_W = 16;

endpackage

// File: rtl/fact_job_scheduler_if.sv
// Requester-side bus of the factorial job scheduler: per-requester request/operand
// lines in, one-hot grant and shared response lines out.
interface fact_job_scheduler_if #(
    parameter int NUM_REQ = 2
);
    import fact_job_scheduler_pkg::*;

    logic [NUM_REQ-1:0]          req;
    logic [FACT_N_W*NUM_REQ-1:0] req_n;
    logic [NUM_REQ-1:0]          gnt;
    logic [NUM_REQ-1:0]          rsp_valid;
    logic [FACT_RES_W-1:0]       rsp_result;
    logic                        rsp_err;

    modport master (
        output req, req_n,
        input  gnt, rsp_valid, rsp_result, rsp_err
    );

    modport slave (
        input  req, req_n,
        output gnt, rsp_valid, rsp_result, rsp_err
    );

endinterface

// File: rtl/fact_job_scheduler_rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, wrapping to the lowest
// asserted request when nothing at/above ptr is pending.
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   index,
    output logic               valid
);

    logic [NUM_REQ-1:0] upper;
    logic [NUM_REQ-1:0] pick_src;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_mask
            assign upper[gi] = req[gi] && (IDX_W'(gi) >= ptr);
        end
    endgenerate

    assign pick_src = (upper != '0) ? upper : req;

    // Scan downwards so the lowest set bit of pick_src is the one that sticks.
    always_comb begin
        index = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (pick_src[i]) begin
                index = IDX_W'(i);
            end
        end
    end

    assign valid = (req != '0);
    assign grant = valid ? (NUM_REQ'(1) << index) : '0;

endmodule

// File: rtl/fact_job_scheduler.sv
// Shares one factorial engine among NUM_REQ requesters, one job at a time, round-robin.
// Optional FACT_OVF_CHECK_EN: operands above 12 are answered with err=1 without launching.
module fact_job_scheduler
    import fact_job_scheduler_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    fact_job_scheduler_if.slave   bus,
    output logic                  busy,
    output logic                  fact_go,
    output logic [FACT_N_W-1:0]   fact_n,
    input  logic                  fact_done,
    input  logic [FACT_RES_W-1:0] fact_result
);

    localparam int IDX_W = $clog2(NUM_REQ);

`ifdef FACT_OVF_CHECK_EN
    localparam bit OVF_CHECK = 1'b1;
`else
    localparam bit OVF_CHECK = 1'b0;
`endif

    state_t                state_reg, state_next;
    logic [IDX_W-1:0]      ptr_reg, ptr_next;
    logic [IDX_W-1:0]      owner_reg, owner_next;
    logic [NUM_REQ-1:0]    gnt_reg, gnt_next;
    logic [FACT_N_W-1:0]   n_reg, n_next;
    logic [TIMER_W-1:0]    cnt_reg, cnt_next;
    logic [FACT_RES_W-1:0] result_reg, result_next;
    logic                  err_reg, err_next;

    logic [NUM_REQ-1:0]    arb_grant;
    logic [IDX_W-1:0]      arb_index;
    logic                  arb_valid;
    logic [FACT_N_W-1:0]   n_arr [NUM_REQ];
    logic [FACT_N_W-1:0]   win_n;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign n_arr[gi] = bus.req_n[FACT_N_W*gi +: FACT_N_W];
        end
    endgenerate

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req   (bus.req),
        .ptr   (ptr_reg),
        .grant (arb_grant),
        .index (arb_index),
        .valid (arb_valid)
    );

    assign win_n = n_arr[arb_index];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            ptr_reg    <= '0;
            owner_reg  <= '0;
            gnt_reg    <= '0;
            n_reg      <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            owner_reg  <= owner_next;
            gnt_reg    <= gnt_next;
            n_reg      <= n_next;
            cnt_reg    <= cnt_next;
            result_reg <= result_next;
            err_reg    <= err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        owner_next  = owner_reg;
        gnt_next    = gnt_reg;
        n_next      = n_reg;
        cnt_next    = cnt_reg;
        result_next = result_reg;
        err_next    = err_reg;

        case (state_reg)
            S_IDLE: begin
                if (arb_valid) begin
                    owner_next = arb_index;
                    gnt_next   = arb_grant;
                    n_next     = win_n;
                    state_next = S_LAUNCH;
                    if (OVF_CHECK && (win_n > FACT_N_W'(FACT_N_MAX))) begin
                        result_next = '0;
                        err_next    = 1'b1;
                        state_next  = S_RESP;
                    end
                end
            end
            // Any fact_done seen here belongs to the previous job and is ignored.
            S_LAUNCH: begin
                cnt_next   = '0;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                cnt_next = cnt_reg + TIMER_W'(1);
                if (fact_done) begin
                    result_next = fact_result;
                    err_next    = 1'b0;
                    state_next  = S_RESP;
                end else if (cnt_next == TIMER_W'(TIMEOUT_CYC)) begin
                    result_next = '0;
                    err_next    = 1'b1;
                    state_next  = S_RESP;
                end
            end
            S_RESP: begin
                ptr_next   = (owner_reg == IDX_W'(NUM_REQ - 1)) ? '0 : owner_reg + IDX_W'(1);
                gnt_next   = '0;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign busy           = (state_reg != S_IDLE);
    assign fact_go        = (state_reg == S_LAUNCH);
    assign fact_n         = n_reg;
    assign bus.gnt        = gnt_reg;
    assign bus.rsp_valid  = (state_reg == S_RESP) ? gnt_reg : '0;
    assign bus.rsp_result = result_reg;
    assign bus.rsp_err    = err_reg;

endmodule

// File: tb/tb_fact_job_scheduler.sv
// Directed bench for fact_job_scheduler: two requesters, short timeout, hand-driven engine.
module tb_fact_job_scheduler;
    import fact_job_scheduler_pkg::*;

    localparam int NUM_REQ     = 2;
    localparam int TIMEOUT_CYC = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        busy;
    logic        fact_go;
    logic [3:0]  fact_n;
    logic        fact_done;
    logic [31:0] fact_result;

    int checks   = 0;
    int failures = 0;

    fact_job_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

    fact_job_scheduler #(
        .NUM_REQ     (NUM_REQ),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .busy        (busy),
        .fact_go     (fact_go),
        .fact_n      (fact_n),
        .fact_done   (fact_done),
        .fact_result (fact_result)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts with req already driven in IDLE; ends back in IDLE one cycle after RESP.
    task automatic run_job(input logic [1:0] exp_gnt, input logic [3:0] exp_n,
                           input logic [31:0] res, input string tag);
        tick();
        checks++;
        if (bus.gnt !== exp_gnt || fact_go !== 1'b1 || fact_n !== exp_n || busy !== 1'b1) begin
            failures++;
            $display("FAIL %s_launch: gnt=%b go=%b n=%0d busy=%b, expected gnt=%b go=1 n=%0d busy=1",
                     tag, bus.gnt, fact_go, fact_n, busy, exp_gnt, exp_n);
        end
        tick();
        checks++;
        if (fact_go !== 1'b0 || bus.rsp_valid !== 2'b00) begin
            failures++;
            $display("FAIL %s_wait: go=%b rsp_valid=%b, expected go=0 rsp_valid=00",
                     tag, fact_go, bus.rsp_valid);
        end
        fact_done   = 1'b1;
        fact_result = res;
        tick();
        checks++;
        if (bus.rsp_valid !== exp_gnt || bus.rsp_result !== res || bus.rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL %s_resp: rsp_valid=%b result=%0d err=%b, expected rsp_valid=%b result=%0d err=0",
                     tag, bus.rsp_valid, bus.rsp_result, bus.rsp_err, exp_gnt, res);
        end
        fact_done = 1'b0;
        $display("job %s owner=%b n=%0d result=%0d err=%b", tag, bus.rsp_valid, exp_n,
                 bus.rsp_result, bus.rsp_err);
        tick();
        checks++;
        if (bus.gnt !== 2'b00 || busy !== 1'b0 || bus.rsp_valid !== 2'b00 || bus.rsp_result !== res) begin
            failures++;
            $display("FAIL %s_idle: gnt=%b busy=%b rsp_valid=%b result=%0d, expected 00 0 00 %0d",
                     tag, bus.gnt, busy, bus.rsp_valid, bus.rsp_result, res);
        end
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        bus.req     = '0;
        bus.req_n   = '0;
        fact_done   = 1'b0;
        fact_result = '0;
        tick();
        tick();
        checks++;
        if (bus.gnt !== 2'b00 || bus.rsp_valid !== 2'b00 || bus.rsp_result !== 32'd0 ||
            bus.rsp_err !== 1'b0 || busy !== 1'b0 || fact_go !== 1'b0 || fact_n !== 4'd0) begin
            failures++;
            $display("FAIL reset: gnt=%b rv=%b res=%0d err=%b busy=%b go=%b n=%0d, expected all zero",
                     bus.gnt, bus.rsp_valid, bus.rsp_result, bus.rsp_err, busy, fact_go, fact_n);
        end
        $display("reset applied");
        rst = 1'b0;
    endtask

    task automatic test_single_job();
        bus.req   = 2'b01;
        bus.req_n = {4'd0, 4'd5};
        run_job(2'b01, 4'd5, 32'd120, "single");
        bus.req = 2'b00;
    endtask

    task automatic test_back_to_back();
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        bus.req   = 2'b11;
        bus.req_n = {4'd4, 4'd3};
        run_job(2'b01, 4'd3, 32'd6,  "rr0_a");
        run_job(2'b10, 4'd4, 32'd24, "rr1_a");
        run_job(2'b01, 4'd3, 32'd6,  "rr0_b");
        run_job(2'b10, 4'd4, 32'd24, "rr1_b");
        bus.req = 2'b00;
    endtask

    task automatic test_timeout();
        bit early;
        bus.req   = 2'b01;
        bus.req_n = {4'd0, 4'd7};
        tick();
        checks++;
        if (fact_go !== 1'b1 || fact_n !== 4'd7) begin
            failures++;
            $display("FAIL timeout_launch: go=%b n=%0d, expected go=1 n=7", fact_go, fact_n);
        end
        early = 1'b0;
        for (int i = 0; i < TIMEOUT_CYC; i++) begin
            tick();
            if (bus.rsp_valid !== 2'b00 || busy !== 1'b1) early = 1'b1;
        end
        checks++;
        if (early) begin
            failures++;
            $display("FAIL timeout_early: response or idle seen within %0d wait cycles, expected none",
                     TIMEOUT_CYC);
        end
        tick();
        checks++;
        if (bus.rsp_valid !== 2'b01 || bus.rsp_result !== 32'd0 || bus.rsp_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_resp: rsp_valid=%b result=%0d err=%b, expected 01 0 1",
                     bus.rsp_valid, bus.rsp_result, bus.rsp_err);
        end
        $display("job timeout owner=%b result=%0d err=%b", bus.rsp_valid, bus.rsp_result, bus.rsp_err);
        bus.req = 2'b00;
        tick();
        checks++;
        if (busy !== 1'b0 || bus.rsp_err !== 1'b1 || bus.rsp_valid !== 2'b00) begin
            failures++;
            $display("FAIL timeout_idle: busy=%b err=%b rv=%b, expected 0 1 00",
                     busy, bus.rsp_err, bus.rsp_valid);
        end
    endtask

    task automatic test_stale_done();
        bus.req   = 2'b01;
        bus.req_n = {4'd0, 4'd4};
        tick();
        fact_done   = 1'b1;
        fact_result = 32'hDEAD_BEEF;
        tick();
        fact_done = 1'b0;
        checks++;
        if (busy !== 1'b1 || bus.rsp_valid !== 2'b00) begin
            failures++;
            $display("FAIL stale_ignored: busy=%b rsp_valid=%b, expected busy=1 rsp_valid=00",
                     busy, bus.rsp_valid);
        end
        tick();
        checks++;
        if (bus.rsp_valid !== 2'b00) begin
            failures++;
            $display("FAIL stale_wait: rsp_valid=%b, expected 00", bus.rsp_valid);
        end
        fact_done   = 1'b1;
        fact_result = 32'd24;
        tick();
        checks++;
        if (bus.rsp_valid !== 2'b01 || bus.rsp_result !== 32'd24 || bus.rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL stale_resp: rsp_valid=%b result=%0d err=%b, expected 01 24 0",
                     bus.rsp_valid, bus.rsp_result, bus.rsp_err);
        end
        $display("job stale owner=%b result=%0d err=%b", bus.rsp_valid, bus.rsp_result, bus.rsp_err);
        fact_done = 1'b0;
        bus.req   = 2'b00;
        tick();
    endtask

    task automatic test_reset_mid_wait();
        bit spurious;
        bus.req   = 2'b01;
        bus.req_n = {4'd0, 4'd9};
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (bus.gnt !== 2'b00 || busy !== 1'b0 || bus.rsp_valid !== 2'b00 || fact_go !== 1'b0) begin
            failures++;
            $display("FAIL midreset: gnt=%b busy=%b rv=%b go=%b, expected 00 0 00 0",
                     bus.gnt, busy, bus.rsp_valid, fact_go);
        end
        $display("reset during wait");
        rst     = 1'b0;
        bus.req = 2'b00;
        spurious = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.rsp_valid !== 2'b00 || busy !== 1'b0) spurious = 1'b1;
        end
        checks++;
        if (spurious) begin
            failures++;
            $display("FAIL midreset_quiet: activity after abandoned job, expected none");
        end
        bus.req   = 2'b01;
        bus.req_n = {4'd0, 4'd3};
        run_job(2'b01, 4'd3, 32'd6, "after_reset");
        bus.req = 2'b00;
    endtask

    task automatic test_overflow();
        bus.req   = 2'b01;
        bus.req_n = {4'd0, 4'd13};
`ifdef FACT_OVF_CHECK_EN
        tick();
        checks++;
        if (bus.gnt !== 2'b01 || bus.rsp_valid !== 2'b01 || bus.rsp_err !== 1'b1 ||
            bus.rsp_result !== 32'd0 || fact_go !== 1'b0) begin
            failures++;
            $display("FAIL ovf_resp: gnt=%b rv=%b err=%b res=%0d go=%b, expected 01 01 1 0 0",
                     bus.gnt, bus.rsp_valid, bus.rsp_err, bus.rsp_result, fact_go);
        end
        $display("job ovf13 owner=%b result=%0d err=%b", bus.rsp_valid, bus.rsp_result, bus.rsp_err);
        bus.req = 2'b00;
        tick();
        checks++;
        if (busy !== 1'b0 || fact_go !== 1'b0) begin
            failures++;
            $display("FAIL ovf_idle: busy=%b go=%b, expected 0 0", busy, fact_go);
        end
        bus.req = 2'b01;
`else
        run_job(2'b01, 4'd13, 32'h7328_CC00, "n13");
`endif
        bus.req_n = {4'd0, 4'd12};
        run_job(2'b01, 4'd12, 32'd479001600, "n12");
        bus.req = 2'b00;
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_back_to_back();
        test_timeout();
        test_stale_done();
        test_reset_mid_wait();
        test_overflow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
